// File: rtl/gdp_pkg.sv
// Shared types and constants for the GDP pipeline and its feeder.
package gdp_pkg;

  typedef logic [15:0] word_t;

  localparam int    GDP_LATENCY = 5;
  localparam word_t LNP_FLOOR   = 16'h8000;

  typedef enum logic [2:0] {
    IDLE,
    ISSUE,
    DRAIN,
    WAIT,
    DONE
  } feeder_state_t;

endpackage

// File: rtl/gdp_feeder.sv
// Sequencer that streams one observation vector and one Gaussian's parameters
// into the GDP pipe, then waits for and returns the resulting ln_p.
module gdp_feeder
  import gdp_pkg::*;
#(
  parameter int NUM_DIM = 39,
  parameter int PADDR_W = 12,
  parameter int XADDR_W = 6
) (
  input  logic               clk,
  input  logic               nreset,
  input  logic               start,
  input  logic [PADDR_W-1:0] param_base,
  output logic               busy,
  output logic [XADDR_W-1:0] x_addr,
  input  word_t              x_data,
  output logic [PADDR_W-1:0] p_addr,
  input  word_t              p_mean,
  input  word_t              p_omega,
  input  word_t              p_k,
  output logic               first_calc,
  output logic               last_calc,
  output word_t              x,
  output word_t              k,
  output word_t              omega,
  output word_t              mean,
  input  word_t              ln_p,
  input  logic               data_ready,
  output word_t              result,
  output logic               result_valid,
  output logic               timeout_err
);

  localparam logic [XADDR_W-1:0] D_LAST = XADDR_W'(NUM_DIM - 1);
  localparam int                 WCNT_W = $clog2(GDP_LATENCY + 3);
  // wcnt holds "cycles since last_calc"; giving up at this value lands DONE
  // on last_calc + GDP_LATENCY + 2.
  localparam logic [WCNT_W-1:0]  WCNT_LAST = WCNT_W'(GDP_LATENCY + 1);

  feeder_state_t       state, state_nx;
  logic [XADDR_W-1:0]  d;
  logic [PADDR_W-1:0]  base_q;
  logic [WCNT_W-1:0]   wcnt;
  word_t               result_q;
  logic                tmo_q;
  logic                vld_p0, first_p0, last_p0;

  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) state <= IDLE;
    else         state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (start) state_nx = ISSUE;
      ISSUE:   if (d == D_LAST) state_nx = DRAIN;
      DRAIN:   state_nx = WAIT;
      WAIT:    if (data_ready || (wcnt == WCNT_LAST)) state_nx = DONE;
      DONE:    state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      d        <= '0;
      base_q   <= '0;
      wcnt     <= '0;
      result_q <= '0;
      tmo_q    <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            base_q <= param_base;
            d      <= '0;
            tmo_q  <= 1'b0;
          end
        end
        ISSUE: d <= d + 1'b1;
        DRAIN: wcnt <= WCNT_W'(1);
        WAIT: begin
          wcnt <= wcnt + 1'b1;
          if (data_ready) begin
            result_q <= ln_p;
          end else if (wcnt == WCNT_LAST) begin
            result_q <= LNP_FLOOR;
            tmo_q    <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  // p0: memory words return one cycle after issue; markers are registered to
  // line up with that return so the operand stream is gap-free.
  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      vld_p0   <= 1'b0;
      first_p0 <= 1'b0;
      last_p0  <= 1'b0;
    end else begin
      vld_p0   <= (state == ISSUE);
      first_p0 <= (state == ISSUE) && (d == '0);
      last_p0  <= (state == ISSUE) && (d == D_LAST);
    end
  end

  assign x_addr       = (state == ISSUE) ? d : '0;
  assign p_addr       = (state == ISSUE) ? base_q + PADDR_W'(d) : '0;
  assign first_calc   = first_p0;
  assign last_calc    = last_p0;
  assign x            = vld_p0  ? x_data  : '0;
  assign mean         = vld_p0  ? p_mean  : '0;
  assign omega        = vld_p0  ? p_omega : '0;
  assign k            = last_p0 ? p_k     : '0;
  assign busy         = (state != IDLE);
  assign result       = result_q;
  assign result_valid = (state == DONE);
  assign timeout_err  = tmo_q;

endmodule

// File: tb/tb_gdp_feeder.sv
// Scoreboard bench for gdp_feeder with behavioural memories and a GDP stub.
module tb_gdp_feeder;

  localparam int N = 39;

  logic        clk, nreset, start;
  logic [11:0] param_base;
  logic        busy;
  logic [5:0]  x_addr;
  logic [15:0] x_data;
  logic [11:0] p_addr;
  logic [15:0] p_mean, p_omega, p_k;
  logic        first_calc, last_calc;
  logic [15:0] x, k, omega, mean, ln_p;
  logic        data_ready;
  logic [15:0] result;
  logic        result_valid, timeout_err;

  gdp_feeder #(.NUM_DIM(N), .PADDR_W(12), .XADDR_W(6)) dut (
    .clk(clk), .nreset(nreset), .start(start), .param_base(param_base),
    .busy(busy), .x_addr(x_addr), .x_data(x_data), .p_addr(p_addr),
    .p_mean(p_mean), .p_omega(p_omega), .p_k(p_k),
    .first_calc(first_calc), .last_calc(last_calc),
    .x(x), .k(k), .omega(omega), .mean(mean),
    .ln_p(ln_p), .data_ready(data_ready),
    .result(result), .result_valid(result_valid), .timeout_err(timeout_err)
  );

  always #5 clk = ~clk;

  // Memories (registered read) and GDP stub
  logic [15:0] xmem [64];
  logic [15:0] pm_mean [4096], pm_omega [4096], pm_k [4096];
  logic [4:0]  dr_sh = '0;
  logic        stub_en;
  logic [15:0] lnp;
  int          cyc = 0;

  always @(posedge clk) begin
    x_data  <= xmem[x_addr];
    p_mean  <= pm_mean[p_addr];
    p_omega <= pm_omega[p_addr];
    p_k     <= pm_k[p_addr];
    dr_sh   <= {dr_sh[3:0], last_calc & stub_en};
    cyc     <= cyc + 1;
  end
  assign data_ready = dr_sh[4];
  assign ln_p       = lnp;

  typedef struct { int cyc; logic [15:0] x, k, omega, mean; logic first, last; } op_t;
  typedef struct { int cyc; logic [5:0] xa; logic [11:0] pa; } ad_t;
  typedef struct { int cyc; logic [15:0] res; logic tmo; } rs_t;
  op_t op_q[$];
  ad_t ad_q[$];
  rs_t rs_q[$];
  op_t mo;
  ad_t ma;
  rs_t mr;

  int n_cmp = 0, n_bad = 0;
  bit mon_en = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s @cyc %0d: got %0h, expected %0h", tag, cyc, got, exp);
    end
  endtask

  always @(negedge clk) begin
    if (mon_en) begin
      if (ad_q.size() > 0 && ad_q[0].cyc == cyc) begin
        ma = ad_q.pop_front();
        check("x_addr", 64'(x_addr), 64'(ma.xa));
        check("p_addr", 64'(p_addr), 64'(ma.pa));
      end else begin
        check("addr_idle", 64'({x_addr, p_addr}), 64'(0));
      end
      if (op_q.size() > 0 && op_q[0].cyc == cyc) begin
        mo = op_q.pop_front();
        check("x", 64'(x), 64'(mo.x));
        check("mean", 64'(mean), 64'(mo.mean));
        check("omega", 64'(omega), 64'(mo.omega));
        check("k", 64'(k), 64'(mo.k));
        check("markers", 64'({first_calc, last_calc}), 64'({mo.first, mo.last}));
      end else begin
        check("op_idle", 64'({first_calc, last_calc, x, k, omega, mean}), 64'(0));
      end
      if (result_valid) begin
        if (rs_q.size() == 0) begin
          check("extra_result_valid", 64'(1), 64'(0));
        end else begin
          mr = rs_q.pop_front();
          check("result", 64'(result), 64'(mr.res));
          check("timeout_err", 64'(timeout_err), 64'(mr.tmo));
          check("rv_cycle", 64'(cyc), 64'(mr.cyc));
          check("busy_at_rv", 64'(busy), 64'(1));
        end
      end
    end
  end

  task automatic start_frame(input logic [11:0] base, input bit tmo, input logic [15:0] lnv);
    int t0;
    logic [11:0] a;
    @(negedge clk);
    start = 1'b1; param_base = base; stub_en = !tmo; lnp = lnv;
    t0 = cyc;
    for (int d = 0; d < N; d++) begin
      a = base + 12'(d);
      ad_q.push_back('{cyc: t0 + 1 + d, xa: 6'(d), pa: a});
      op_q.push_back('{cyc: t0 + 2 + d, x: xmem[d], mean: pm_mean[a], omega: pm_omega[a],
                       k: (d == N - 1) ? pm_k[a] : 16'h0, first: (d == 0), last: (d == N - 1)});
    end
    rs_q.push_back('{cyc: tmo ? t0 + N + 8 : t0 + N + 7, res: tmo ? 16'h8000 : lnv, tmo: tmo});
    @(negedge clk);
    start = 1'b0; param_base = 12'($urandom);
    check("busy_after_start", 64'(busy), 64'(1));
  endtask

  task automatic wait_done();
    for (int i = 0; i < 80 && rs_q.size() > 0; i++) @(negedge clk);
    if (rs_q.size() > 0) begin
      check("result_wait_bound", 64'(0), 64'(1));
      rs_q.delete(); op_q.delete(); ad_q.delete();
    end
    @(negedge clk);
    check("busy_after_done", 64'(busy), 64'(0));
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_ctl"}, 64'({busy, result_valid, timeout_err, first_calc, last_calc}), 64'(0));
    check({tag, "_addr"}, 64'({x_addr, p_addr}), 64'(0));
    check({tag, "_ops"}, 64'({x, k, omega, mean}), 64'(0));
    check({tag, "_result"}, 64'(result), 64'(0));
  endtask

  initial begin
    clk = 0; nreset = 1; start = 0; param_base = '0; stub_en = 0; lnp = '0;
    for (int i = 0; i < 64; i++) xmem[i] = 16'($urandom);
    for (int i = 0; i < 4096; i++) begin
      pm_mean[i] = 16'($urandom); pm_omega[i] = 16'($urandom); pm_k[i] = 16'($urandom);
    end
    #1 nreset = 0;
    repeat (3) @(negedge clk);
    check_all_zero("reset");
    #2 nreset = 1;
    mon_en = 1;

    // Plain frame with a known result value
    start_frame(12'h123, 0, 16'h0ABC);
    wait_done();

    // Parameter address wraps FFE, FFF, 000, 001, ...
    start_frame(12'hFFE, 0, 16'($urandom));
    wait_done();

    // Second start during ISSUE must be ignored
    start_frame(12'h400, 0, 16'h1357);
    repeat (3) @(negedge clk);
    start = 1'b1; param_base = 12'h800;
    @(negedge clk);
    start = 1'b0;
    wait_done();
    repeat (10) @(negedge clk);

    // No data_ready: floor result and sticky timeout flag
    start_frame(12'h010, 1, 16'h0);
    wait_done();
    repeat (5) @(negedge clk);
    check("tmo_sticky", 64'(timeout_err), 64'(1));
    check("floor_held", 64'(result), 64'(16'h8000));

    // Next start clears timeout; then reset lands mid-ISSUE at d=10
    start_frame(12'h200, 0, 16'h2468);
    check("tmo_cleared", 64'(timeout_err), 64'(0));
    repeat (10) @(negedge clk);
    check("pre_reset_d10", 64'(x_addr), 64'(10));
    #2 nreset = 0;
    #1 check_all_zero("midframe_reset");
    op_q.delete(); ad_q.delete(); rs_q.delete();
    stub_en = 0;
    repeat (3) @(negedge clk);
    #2 nreset = 1;
    repeat (2) @(negedge clk);

    // Clean full frame after reset release
    start_frame(12'h7C0, 0, 16'($urandom));
    wait_done();
    repeat (5) @(negedge clk);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
